// File: rtl/uart_receiver_if.sv
// uart_receiver_if: valid/ready byte handshake between the receiver and its consumer
interface uart_receiver_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with valid/ready output (8E1 when UART_RX_PARITY_EN is defined)
module uart_receiver #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int OVERSAMPLE   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RxD,
   uart_receiver_if.master  bus,
   output logic             frame_err,
   output logic             overrun,
`ifdef UART_RX_PARITY_EN
   output logic             parity_err,
`endif
   output logic             busy
);
   localparam int TICK_DIV = CLKS_PER_BIT / OVERSAMPLE;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t          r_state;
   logic            r_sync1, r_rx_s, r_rx_prev;
   logic [TW-1:0]   r_tick_cnt;
   logic [SW-1:0]   r_sample_cnt;
   logic            r_smp_a, r_smp_b;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shreg, r_data;
   logic            r_valid, r_deliver, r_frame_err, r_overrun, r_busy;
`ifdef UART_RX_PARITY_EN
   logic            r_par_bad, r_parity_err;
`endif
   logic            w_start, w_tick, w_vtick, w_vote;

   assign w_start = (r_state == S_IDLE) && r_rx_prev && !r_rx_s;
   assign w_tick  = (r_tick_cnt == TICK_LAST);
   assign w_vtick = w_tick && (r_sample_cnt == SMP_C);
   assign w_vote  = (r_smp_a & r_smp_b) | (r_smp_a & r_rx_s) | (r_smp_b & r_rx_s);

   assign bus.data  = r_data;
   assign bus.valid = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
   assign parity_err = r_parity_err;
`endif

   // two-flop synchronizer plus one more stage for falling-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= RxD;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
      end
   end

   // oversample tick and sample position, realigned to each start edge; captures the first two vote samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tick_cnt   <= '0;
         r_sample_cnt <= '0;
         r_smp_a      <= 1'b1;
         r_smp_b      <= 1'b1;
      end else if (w_start) begin
         r_tick_cnt   <= '0;
         r_sample_cnt <= '0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_tick) begin
            r_sample_cnt <= (r_sample_cnt == SMP_LAST) ? '0 : r_sample_cnt + 1'b1;
            if (r_sample_cnt == SMP_A) r_smp_a <= r_rx_s;
            if (r_sample_cnt == SMP_B) r_smp_b <= r_rx_s;
         end
      end
   end

   // frame FSM with registered flags and the consumer handshake
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_shreg     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bad    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: if (w_start) begin
               r_state <= S_START;
               r_busy  <= 1'b1;
            end
            S_START: if (w_vtick) begin
               r_state   <= w_vote ? S_IDLE : S_DATA;
               r_busy    <= !w_vote;
               r_bit_cnt <= '0;
            end
            S_DATA: if (w_vtick) begin
               r_shreg   <= {w_vote, r_shreg[7:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
               if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
`else
               if (r_bit_cnt == 3'd7) r_state <= S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (w_vtick) begin
               r_par_bad <= (^r_shreg) ^ w_vote;
               r_state   <= S_STOP;
            end
`endif
            S_STOP: if (w_vtick) begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_deliver   <= w_vote;
               r_frame_err <= !w_vote;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
         if (r_valid && bus.ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
         if (r_deliver) begin
            if (r_valid && !bus.ready) begin
               r_overrun <= 1'b1;
            end else begin
               r_data  <= r_shreg;
               r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
               r_parity_err <= r_par_bad;
`endif
            end
         end
      end
   end
endmodule
